// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for the MAC-lane array: walks every (row, column-group) tile
// of C = A*B^T, launches the lanes, collects their done flags, hands each
// finished tile to the output streamer and flags job completion.
module matmul_tile_scheduler #(
    parameter int MATSIZE = 16,
    parameter int LANES   = 4,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              mul_start,
    output logic [ADDR_W-1:0] a_base,
    output logic [ADDR_W-1:0] b_base,
    input  logic [LANES-1:0]  lane_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_row,
    output logic [7:0]        out_cgrp,
    output logic              done_intr,
    output logic              err
);

    localparam int CGRPS = MATSIZE / LANES;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        row;
    logic [7:0]        cgrp;
    logic [LANES-1:0]  done_mask;
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_q;

    logic [LANES-1:0]  mask_now;
    logic              mask_full;
    logic              timeout_hit;
    logic              last_cgrp;
    logic              last_tile;
    logic              handshake;

    // Lane completion includes flags arriving in the current cycle; the
    // counter holds cycles already spent, so the limit is hit on the
    // TIMEOUT-th WAIT cycle.
    always_comb begin
        mask_now    = done_mask | lane_done;
        mask_full   = (mask_now == '1);
        timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
        last_cgrp   = (cgrp == 8'(CGRPS - 1));
        last_tile   = last_cgrp && (row == 8'(MATSIZE - 1));
        handshake   = (state == S_DRAIN) && out_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_ISSUE;
                S_ISSUE: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (mask_full) begin
                        state_nxt = S_DRAIN;
                    end else if (timeout_hit) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_DRAIN: if (out_ready) state_nxt = last_tile ? S_DONE : S_ISSUE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Tile position, lane-done mask, wait counter and sticky error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row       <= '0;
            cgrp      <= '0;
            done_mask <= '0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row   <= '0;
                        cgrp  <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    done_mask <= '0;
                    wait_cnt  <= '0;
                end
                S_WAIT: begin
                    done_mask <= mask_now;
                    wait_cnt  <= wait_cnt + CNT_W'(1);
                    if (!mask_full && timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (handshake) begin
                        if (last_cgrp) begin
                            cgrp <= '0;
                            row  <= row + 8'd1;
                        end else begin
                            cgrp <= cgrp + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from state; bases are only driven while a tile
    // is in flight so that idle/reset outputs read all zero
    always_comb begin
        busy      = 1'b0;
        mul_start = 1'b0;
        a_base    = '0;
        b_base    = '0;
        out_valid = 1'b0;
        out_row   = '0;
        out_cgrp  = '0;
        done_intr = 1'b0;
        err       = err_q;
        case (state)
            S_ISSUE, S_WAIT: begin
                busy      = 1'b1;
                mul_start = (state == S_ISSUE);
                a_base    = ADDR_W'(32'(row) * MATSIZE);
                b_base    = ADDR_W'(MATSIZE * MATSIZE + 32'(cgrp) * LANES * MATSIZE);
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_row   = row;
                out_cgrp  = cgrp;
            end
            S_DONE: begin
                busy      = 1'b1;
                done_intr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
